// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the activation row fetcher.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  localparam int FIFO_DEPTH  = 2;
  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry synchronous FIFO between the SRAM read port and the row consumer.
module fetch_fifo2
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 72
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // The upstream credit rule keeps the FIFO from ever overflowing.
  overflow_a: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && count_q == 2'd2));
  underflow_a: assert property (@(posedge clk) disable iff (!reset)
    !(pop && count_q == 2'd0));

endmodule

// File: rtl/act_row_fetch.sv
// Walks a rectangular activation-buffer region row by row and streams words to the SIPO.
// Optional FETCH_STALL_CNT_EN adds a saturating backpressure cycle counter on stall_cnt.
module act_row_fetch
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH    = 72,
  parameter int ADDR_WIDTH    = 10,
  parameter int ROW_WORDS     = 3,
  parameter int ROW_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [ADDR_WIDTH-1:0]    row_stride,
  input  logic [ROW_CNT_WIDTH-1:0] num_rows,
  output logic                     sram_rd_en,
  output logic [ADDR_WIDTH-1:0]    sram_addr,
  input  logic [DATA_WIDTH-1:0]    sram_rd_data,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     row_done,
  output logic                     frame_done,
  output logic                     busy,
  output logic [STALL_CNT_W-1:0]   stall_cnt,
  output fetch_state_e             dbg_state
);

  localparam int WIW = idx_width(ROW_WORDS);
  localparam logic [WIW-1:0] LAST_WORD = WIW'(ROW_WORDS - 1);

  fetch_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]    stride_q, stride_d;
  logic [ROW_CNT_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [ADDR_WIDTH-1:0]    row_base_q, row_base_d;
  logic [WIW-1:0]           word_idx_q, word_idx_d;
  logic [ROW_CNT_WIDTH-1:0] row_idx_q, row_idx_d;
  logic [WIW-1:0]           out_word_idx_q, out_word_idx_d;
  logic [ROW_CNT_WIDTH-1:0] out_row_idx_q, out_row_idx_d;
  logic                     inflight_q, inflight_d;
  logic                     row_done_q, row_done_d;
  logic                     last_xfer_q, last_xfer_d;

  logic       start_acc;
  logic       pop;
  logic       push;
  logic       issue;
  logic       last_word_iss;
  logic       last_row_iss;
  logic       last_word_out;
  logic       last_row_out;
  logic [1:0] fifo_count;
  logic [2:0] credit_used;

  // Handshake: a word transfers on any cycle with out_valid && out_ready; while
  // out_valid is high and out_ready low, out_data holds the same head word.
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !clear;
  assign start_acc = (state_q == IDLE) && start && !clear;

  // Credit counts FIFO entries left after this cycle's pop plus the word returning now.
  assign credit_used = 3'(fifo_count) - 3'(pop) + 3'(inflight_q);
  assign issue       = (state_q == FETCH) && !clear && (credit_used < 3'(FIFO_DEPTH));

  assign last_word_iss = (word_idx_q == LAST_WORD);
  assign last_row_iss  = (row_idx_q == num_rows_q - ROW_CNT_WIDTH'(1));
  assign last_word_out = (out_word_idx_q == LAST_WORD);
  assign last_row_out  = (out_row_idx_q == num_rows_q - ROW_CNT_WIDTH'(1));

  fetch_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (sram_rd_data),
    .pop       (pop),
    .count     (fifo_count),
    .head_data (out_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = (num_rows == '0) ? DONE : FETCH;
      FETCH:   if (issue && last_word_iss && last_row_iss) state_d = DRAIN;
      DRAIN:   if (last_xfer_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    stride_d       = stride_q;
    num_rows_d     = num_rows_q;
    row_base_d     = row_base_q;
    word_idx_d     = word_idx_q;
    row_idx_d      = row_idx_q;
    out_word_idx_d = out_word_idx_q;
    out_row_idx_d  = out_row_idx_q;
    inflight_d     = issue;
    row_done_d     = 1'b0;
    last_xfer_d    = 1'b0;

    if (issue) begin
      if (last_word_iss) begin
        word_idx_d = '0;
        row_base_d = row_base_q + stride_q;
        row_idx_d  = row_idx_q + 1'b1;
      end else begin
        word_idx_d = word_idx_q + 1'b1;
      end
    end

    if (pop) begin
      if (last_word_out) begin
        out_word_idx_d = '0;
        out_row_idx_d  = out_row_idx_q + 1'b1;
        row_done_d     = !clear;
        last_xfer_d    = !clear && last_row_out;
      end else begin
        out_word_idx_d = out_word_idx_q + 1'b1;
      end
    end

    if (start_acc) begin
      stride_d       = row_stride;
      num_rows_d     = num_rows;
      row_base_d     = base_addr;
      word_idx_d     = '0;
      row_idx_d      = '0;
      out_word_idx_d = '0;
      out_row_idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      stride_q       <= '0;
      num_rows_q     <= '0;
      row_base_q     <= '0;
      word_idx_q     <= '0;
      row_idx_q      <= '0;
      out_word_idx_q <= '0;
      out_row_idx_q  <= '0;
      inflight_q     <= 1'b0;
      row_done_q     <= 1'b0;
      last_xfer_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      stride_q       <= stride_d;
      num_rows_q     <= num_rows_d;
      row_base_q     <= row_base_d;
      word_idx_q     <= word_idx_d;
      row_idx_q      <= row_idx_d;
      out_word_idx_q <= out_word_idx_d;
      out_row_idx_q  <= out_row_idx_d;
      inflight_q     <= inflight_d;
      row_done_q     <= row_done_d;
      last_xfer_q    <= last_xfer_d;
    end
  end

  assign sram_rd_en = issue;
  assign sram_addr  = row_base_q + ADDR_WIDTH'(word_idx_q);
  assign row_done   = row_done_q;
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

`ifdef FETCH_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (clear || start_acc) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_act_row_fetch.sv
// Directed bench for act_row_fetch: frame walk, backpressure, wrap, empty frame, abort, reset.
module tb_act_row_fetch;
  import fetch_pkg::*;

  localparam int DW = 72;
  localparam int AW = 10;
  localparam int RW = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] row_stride = '0;
  logic [CW-1:0] num_rows = '0;
  logic          sram_rd_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_rd_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          row_done;
  logic          frame_done;
  logic          busy;
  logic [15:0]   stall_cnt;
  fetch_state_e  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  logic [AW-1:0] rd_q[$];
  int            rd_cyc_q[$];
  logic [DW-1:0] xfer_q[$];
  logic [DW-1:0] exp_q[$];
  int            row_done_cyc_q[$];
  int            row_done_at_q[$];
  int            frame_done_cnt, frame_done_cyc, first_valid_cyc, reads_at_stall_end;
  bit            stable_ok, any_valid;

  logic [AW-1:0] basic_addr[6] = '{10'h010, 10'h011, 10'h012, 10'h018, 10'h019, 10'h01A};
  logic [AW-1:0] wrap_addr[6]  = '{10'h3FE, 10'h3FF, 10'h000, 10'h3FF, 10'h000, 10'h001};

  always #5 clk = ~clk;

  act_row_fetch #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_WORDS(RW), .ROW_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .base_addr(base_addr), .row_stride(row_stride), .num_rows(num_rows),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rd_data(sram_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .row_done(row_done), .frame_done(frame_done), .busy(busy),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return {8'hC3, 54'(a) * 54'd1000003, a};
  endfunction

  // One-cycle-latency SRAM returning an address-derived pattern.
  always @(posedge clk) if (sram_rd_en) sram_rd_data <= word_of(sram_addr);

  // Launch a frame and record reads, transfers and pulses until busy drops.
  task automatic run_frame(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] n,
                           input int stall, input bit restart, output bit timed_out);
    int stall_left;
    bit seen_valid, have_held;
    logic [DW-1:0] held;
    rd_q.delete(); rd_cyc_q.delete(); xfer_q.delete();
    row_done_cyc_q.delete(); row_done_at_q.delete();
    frame_done_cnt = 0; frame_done_cyc = -1; first_valid_cyc = -1; reads_at_stall_end = -1;
    stable_ok = 1'b1; any_valid = 1'b0; seen_valid = 1'b0; have_held = 1'b0; held = '0;
    stall_left = stall; timed_out = 1'b1;
    base_addr = b; row_stride = s; num_rows = n; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!busy) begin timed_out = 1'b0; break; end
      start = 1'b0;
      if (restart && cyc == 4) begin
        base_addr = 10'h200; row_stride = 10'h040; num_rows = 8'd5; start = 1'b1;
      end
      if (out_valid && !seen_valid) begin seen_valid = 1'b1; first_valid_cyc = cyc; end
      if (seen_valid && stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else out_ready = 1'b1;
      @(negedge clk);
      if (sram_rd_en) begin rd_q.push_back(sram_addr); rd_cyc_q.push_back(cyc); end
      if (out_valid) any_valid = 1'b1;
      if (row_done) begin row_done_cyc_q.push_back(cyc); row_done_at_q.push_back(xfer_q.size()); end
      if (frame_done) begin frame_done_cnt++; frame_done_cyc = cyc; end
      if (out_valid && out_ready) xfer_q.push_back(out_data);
      if (out_valid && !out_ready) begin
        if (have_held && out_data !== held) stable_ok = 1'b0;
        held = out_data; have_held = 1'b1;
        reads_at_stall_end = rd_q.size();
      end
      @(posedge clk); #1;
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if ({sram_rd_en, out_valid, row_done, frame_done, busy} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 00000", {sram_rd_en, out_valid, row_done, frame_done, busy}); end
    tests_run++; if (sram_addr !== '0 || out_data !== '0 || stall_cnt !== '0) begin
      tests_failed++; $display("FAIL reset_buses: got addr=%0h data=%0h stall=%0h expected 0", sram_addr, out_data, stall_cnt); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (dbg_state !== IDLE || busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idle: got state=%0d busy=%b expected 0/0", dbg_state, busy); end
  endtask

  task automatic test_basic_frame();
    bit to;
    run_frame(10'h010, 10'h008, 8'd2, 0, 1'b0, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout: got %b expected 0", to); end
    tests_run++; if (rd_q.size() !== 6) begin tests_failed++; $display("FAIL basic_rd_count: got %0d expected 6", rd_q.size()); end
    for (int i = 0; i < 6; i++) if (i < rd_q.size()) begin
      tests_run++; if (rd_q[i] !== basic_addr[i] || rd_cyc_q[i] !== i) begin tests_failed++;
        $display("FAIL basic_rd%0d: got addr=%0h cyc=%0d expected addr=%0h cyc=%0d", i, rd_q[i], rd_cyc_q[i], basic_addr[i], i); end
    end
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(word_of(basic_addr[i]));
    tests_run++; if (xfer_q.size() !== 6) begin tests_failed++; $display("FAIL basic_xfer_count: got %0d expected 6", xfer_q.size()); end
    for (int i = 0; i < 6; i++) if (i < xfer_q.size()) begin
      tests_run++; if (xfer_q[i] !== exp_q[i]) begin tests_failed++;
        $display("FAIL basic_data%0d: got %0h expected %0h", i, xfer_q[i], exp_q[i]); end
    end
    tests_run++; if (first_valid_cyc !== 2) begin tests_failed++; $display("FAIL basic_first_valid: got %0d expected 2", first_valid_cyc); end
    tests_run++; if (row_done_cyc_q.size() !== 2) begin tests_failed++; $display("FAIL basic_row_done_count: got %0d expected 2", row_done_cyc_q.size()); end
    else begin
      tests_run++; if (row_done_cyc_q[0] !== 5 || row_done_cyc_q[1] !== 8 || row_done_at_q[0] !== 3 || row_done_at_q[1] !== 6) begin
        tests_failed++; $display("FAIL basic_row_done: got cyc %0d,%0d after %0d,%0d xfers expected cyc 5,8 after 3,6",
          row_done_cyc_q[0], row_done_cyc_q[1], row_done_at_q[0], row_done_at_q[1]); end
    end
    tests_run++; if (frame_done_cnt !== 1 || frame_done_cyc !== 9) begin tests_failed++;
      $display("FAIL basic_frame_done: got count=%0d cyc=%0d expected 1/9", frame_done_cnt, frame_done_cyc); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [15:0] exp_stall;
`ifdef FETCH_STALL_CNT_EN
    exp_stall = 16'd10;
`else
    exp_stall = 16'd0;
`endif
    run_frame(10'h010, 10'h008, 8'd2, 10, 1'b0, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout: got %b expected 0", to); end
    tests_run++; if (reads_at_stall_end !== 2) begin tests_failed++; $display("FAIL bp_reads_in_stall: got %0d expected 2", reads_at_stall_end); end
    tests_run++; if (stable_ok !== 1'b1) begin tests_failed++; $display("FAIL bp_data_stable: got %b expected 1", stable_ok); end
    tests_run++; if (xfer_q.size() !== 6) begin tests_failed++; $display("FAIL bp_xfer_count: got %0d expected 6", xfer_q.size()); end
    for (int i = 0; i < 6; i++) if (i < xfer_q.size()) begin
      tests_run++; if (xfer_q[i] !== word_of(basic_addr[i])) begin tests_failed++;
        $display("FAIL bp_data%0d: got %0h expected %0h", i, xfer_q[i], word_of(basic_addr[i])); end
    end
    tests_run++; if (row_done_at_q.size() !== 2 || frame_done_cnt !== 1) begin tests_failed++;
      $display("FAIL bp_pulses: got row_done=%0d frame_done=%0d expected 2/1", row_done_at_q.size(), frame_done_cnt); end
    tests_run++; if (stall_cnt !== exp_stall) begin tests_failed++; $display("FAIL bp_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_addr_wrap();
    bit to;
    run_frame(10'h3FE, 10'h001, 8'd2, 0, 1'b0, to);
    tests_run++; if (to !== 1'b0 || rd_q.size() !== 6) begin tests_failed++;
      $display("FAIL wrap_rd_count: got timeout=%b count=%0d expected 0/6", to, rd_q.size()); end
    for (int i = 0; i < 6; i++) if (i < rd_q.size()) begin
      tests_run++; if (rd_q[i] !== wrap_addr[i]) begin tests_failed++;
        $display("FAIL wrap_rd%0d: got %0h expected %0h", i, rd_q[i], wrap_addr[i]); end
    end
    tests_run++; if (xfer_q.size() !== 6 || (xfer_q.size() == 6 && xfer_q[5] !== word_of(10'h001))) begin tests_failed++;
      $display("FAIL wrap_last_data: got count=%0d expected 6 words ending %0h", xfer_q.size(), word_of(10'h001)); end
  endtask

  task automatic test_empty_frame();
    bit to;
    run_frame(10'h123, 10'h004, 8'd0, 0, 1'b0, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL empty_timeout: got %b expected 0", to); end
    tests_run++; if (rd_q.size() !== 0 || any_valid !== 1'b0) begin tests_failed++;
      $display("FAIL empty_activity: got reads=%0d valid=%b expected 0/0", rd_q.size(), any_valid); end
    tests_run++; if (frame_done_cnt !== 1 || frame_done_cyc !== 0) begin tests_failed++;
      $display("FAIL empty_frame_done: got count=%0d cyc=%0d expected 1/0", frame_done_cnt, frame_done_cyc); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL empty_idle: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_start_while_busy();
    bit to;
    run_frame(10'h010, 10'h008, 8'd2, 0, 1'b1, to);
    tests_run++; if (to !== 1'b0 || rd_q.size() !== 6 || frame_done_cnt !== 1) begin tests_failed++;
      $display("FAIL restart_shape: got timeout=%b reads=%0d frame_done=%0d expected 0/6/1", to, rd_q.size(), frame_done_cnt); end
    for (int i = 0; i < 6; i++) if (i < rd_q.size()) begin
      tests_run++; if (rd_q[i] !== basic_addr[i]) begin tests_failed++;
        $display("FAIL restart_rd%0d: got %0h expected %0h", i, rd_q[i], basic_addr[i]); end
    end
  endtask

  task automatic test_abort();
    bit to, quiet;
    logic [AW-1:0] last_rd;
    int nrd;
    nrd = 0; last_rd = '0; quiet = 1'b1;
    base_addr = 10'h040; row_stride = 10'h010; num_rows = 8'd4; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (sram_rd_en) begin nrd++; last_rd = sram_addr; end
      @(posedge clk); #1;
    end
    tests_run++; if (nrd !== 4 || last_rd !== 10'h050) begin tests_failed++;
      $display("FAIL abort_setup: got reads=%0d last=%0h expected 4/050", nrd, last_rd); end
    clear = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; out_ready = 1'b1;
    tests_run++; if ({busy, out_valid, row_done, frame_done} !== 4'b0 || dbg_state !== IDLE) begin tests_failed++;
      $display("FAIL abort_next: got busy/valid/row/frame=%b state=%0d expected 0000/0", {busy, out_valid, row_done, frame_done}, dbg_state); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid || row_done || frame_done || sram_rd_en) quiet = 1'b0;
    end
    tests_run++; if (quiet !== 1'b1) begin tests_failed++; $display("FAIL abort_quiet: got %b expected 1", quiet); end
    @(posedge clk); #1;
    run_frame(10'h010, 10'h008, 8'd2, 0, 1'b0, to);
    tests_run++; if (to !== 1'b0 || xfer_q.size() !== 6 || frame_done_cnt !== 1) begin tests_failed++;
      $display("FAIL abort_rerun: got timeout=%b xfers=%0d frame_done=%0d expected 0/6/1", to, xfer_q.size(), frame_done_cnt); end
    for (int i = 0; i < 6; i++) if (i < xfer_q.size()) begin
      tests_run++; if (xfer_q[i] !== word_of(basic_addr[i])) begin tests_failed++;
        $display("FAIL abort_rerun_data%0d: got %0h expected %0h", i, xfer_q[i], word_of(basic_addr[i])); end
    end
  endtask

  task automatic test_async_reset();
    base_addr = 10'h010; row_stride = 10'h008; num_rows = 8'd2; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (out_valid !== 1'b1 || busy !== 1'b1) begin tests_failed++;
      $display("FAIL areset_pre: got valid=%b busy=%b expected 1/1", out_valid, busy); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if ({sram_rd_en, out_valid, row_done, frame_done, busy} !== 5'b0 || sram_addr !== '0 || out_data !== '0) begin
      tests_failed++; $display("FAIL areset_now: got flags=%b addr=%0h data=%0h expected 0", {sram_rd_en, out_valid, row_done, frame_done, busy}, sram_addr, out_data); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0 || dbg_state !== IDLE) begin tests_failed++;
      $display("FAIL areset_after: got busy=%b state=%0d expected 0/0", busy, dbg_state); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_addr_wrap();
    test_empty_frame();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
